// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller beside the ID stage of the 5-stage MIPS pipeline:
// load-use interlock, HI/LO unit occupancy tracking and control-transfer squash.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned BR_BUBBLES  = 1,
  parameter int unsigned JMP_BUBBLES = 3,
  parameter bit          MD_BLOCKING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic [1:0]  stall_cause
);

  typedef enum logic {IDLE, CTRL} state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_LU   = 2'd1;
  localparam logic [1:0] CAUSE_MD   = 2'd2;
  localparam logic [1:0] CAUSE_CTRL = 2'd3;

  state_e     state_q, state_d;
  logic [5:0] md_cnt_q, md_cnt_d;
  logic [3:0] ctrl_cnt_q, ctrl_cnt_d;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  logic       is_md, is_mult, is_hl, is_br, is_jmp, uses_rt;
  logic       unused_instr_bits;
  logic       busy, lu_hazard, md_hazard, accept;

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign funct  = id_instr[5:0];
  assign unused_instr_bits = ^id_instr[15:6];

  assign is_md   = (opcode == 6'd0) && (funct inside {6'd24, 6'd25, 6'd26, 6'd27});
  assign is_mult = (funct == 6'd24) || (funct == 6'd25);
  assign is_hl   = (opcode == 6'd0) && ((funct == 6'd16) || (funct == 6'd18));
  assign is_br   = (opcode == 6'd4) || (opcode == 6'd5);
  assign is_jmp  = (opcode == 6'd2) || (opcode == 6'd3);
  assign uses_rt = (opcode == 6'd0) || (opcode == 6'd4) || (opcode == 6'd5) || (opcode == 6'd43);

  assign busy      = (md_cnt_q != 6'd0);
  assign lu_hazard = ex_memread && id_valid && (ex_rt != 5'd0) &&
                     ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  assign md_hazard = busy && (MD_BLOCKING || (id_valid && (is_md || is_hl)));
  // Nothing is accepted while squashing; ID only holds a dead fetch then.
  assign accept    = id_valid && !lu_hazard && !md_hazard && (state_q == IDLE);

  always_comb begin
    md_cnt_d   = busy ? md_cnt_q - 6'd1 : 6'd0;
    state_d    = state_q;
    ctrl_cnt_d = ctrl_cnt_q;
    if (accept && is_md) begin
      md_cnt_d = is_mult ? 6'(MULT_CYCLES) : 6'(DIV_CYCLES);
    end
    case (state_q)
      IDLE: begin
        if (accept && is_br && (BR_BUBBLES != 0)) begin
          state_d    = CTRL;
          ctrl_cnt_d = 4'(BR_BUBBLES);
        end else if (accept && is_jmp && (JMP_BUBBLES != 0)) begin
          state_d    = CTRL;
          ctrl_cnt_d = 4'(JMP_BUBBLES);
        end
      end
      CTRL: begin
        ctrl_cnt_d = ctrl_cnt_q - 4'd1;
        if (ctrl_cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      md_cnt_q   <= 6'd0;
      ctrl_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      ctrl_cnt_q <= ctrl_cnt_d;
    end
  end

  // Priority: load-use, then HI/LO occupancy, then control squash.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_cause = CAUSE_NONE;
    md_busy     = busy && !rst;
    if (!rst) begin
      if (lu_hazard) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        stall_cause = CAUSE_LU;
      end else if (md_hazard) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        stall_cause = CAUSE_MD;
      end else if (state_q == CTRL) begin
        ifid_flush  = 1'b1;
        stall_cause = CAUSE_CTRL;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three differently configured instances share one
// stimulus stream and are checked against directed constants and a cycle model.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_memread;
  logic [4:0]  ex_rt;

  // Packed view per instance: {pc_en, ifid_en, ifid_flush, idex_bubble, md_busy, cause[1:0]}
  wire [6:0] act0, act1, act2;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] NEUTRAL = 7'b1100000;

  int cfg_mult [3] = '{32, 5, 3};
  int cfg_div  [3] = '{32, 8, 4};
  int cfg_br   [3] = '{1, 2, 0};
  int cfg_jmp  [3] = '{3, 3, 0};
  bit cfg_blk  [3] = '{1'b1, 1'b0, 1'b0};

  int md_left     [3] = '{0, 0, 0};
  int squash_left [3] = '{0, 0, 0};

  hazard_stall_ctrl #(.MULT_CYCLES(32), .DIV_CYCLES(32), .BR_BUBBLES(1),
                      .JMP_BUBBLES(3), .MD_BLOCKING(1'b1)) u0 (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .pc_en(act0[6]), .ifid_en(act0[5]),
    .ifid_flush(act0[4]), .idex_bubble(act0[3]), .md_busy(act0[2]),
    .stall_cause(act0[1:0]));

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(8), .BR_BUBBLES(2),
                      .JMP_BUBBLES(3), .MD_BLOCKING(1'b0)) u1 (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .pc_en(act1[6]), .ifid_en(act1[5]),
    .ifid_flush(act1[4]), .idex_bubble(act1[3]), .md_busy(act1[2]),
    .stall_cause(act1[1:0]));

  hazard_stall_ctrl #(.MULT_CYCLES(3), .DIV_CYCLES(4), .BR_BUBBLES(0),
                      .JMP_BUBBLES(0), .MD_BLOCKING(1'b0)) u2 (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .pc_en(act2[6]), .ifid_en(act2[5]),
    .ifid_flush(act2[4]), .idex_bubble(act2[3]), .md_busy(act2[2]),
    .stall_cause(act2[1:0]));

  always #5 clk = ~clk;

  function automatic logic [6:0] get_act(int k);
    case (k)
      0:       return act0;
      1:       return act1;
      default: return act2;
    endcase
  endfunction

  function automatic int op_of(logic [31:0] i);
    return int'(i >> 26);
  endfunction

  function automatic int fn_of(logic [31:0] i);
    return int'(i % 64);
  endfunction

  function automatic bit model_lu();
    int rs = int'((id_instr >> 21) % 32);
    int rt = int'((id_instr >> 16) % 32);
    int op = op_of(id_instr);
    bit reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    return ex_memread && id_valid && (ex_rt != 0) &&
           ((int'(ex_rt) == rs) || (reads_rt && (int'(ex_rt) == rt)));
  endfunction

  function automatic bit model_mh(int k);
    int  op = op_of(id_instr);
    int  fn = fn_of(id_instr);
    bit  md = (op == 0) && (fn >= 24) && (fn <= 27);
    bit  hl = (op == 0) && ((fn == 16) || (fn == 18));
    return (md_left[k] > 0) && (cfg_blk[k] || (id_valid && (md || hl)));
  endfunction

  function automatic logic [6:0] model_out(int k);
    logic busy = (md_left[k] > 0);
    if (rst)                 return NEUTRAL;
    if (model_lu())          return {4'b0001, busy, 2'd1};
    if (model_mh(k))         return {4'b0001, busy, 2'd2};
    if (squash_left[k] > 0)  return {4'b1110, busy, 2'd3};
    return {4'b1100, busy, 2'd0};
  endfunction

  function automatic void model_advance(int k);
    int op = op_of(id_instr);
    int fn = fn_of(id_instr);
    bit take;
    if (rst) begin
      md_left[k]     = 0;
      squash_left[k] = 0;
      return;
    end
    take = id_valid && !model_lu() && !model_mh(k) && (squash_left[k] == 0);
    if (squash_left[k] > 0) squash_left[k] = squash_left[k] - 1;
    if (md_left[k] > 0)     md_left[k] = md_left[k] - 1;
    if (take) begin
      if (op == 0 && (fn == 24 || fn == 25)) md_left[k] = cfg_mult[k];
      if (op == 0 && (fn == 26 || fn == 27)) md_left[k] = cfg_div[k];
      if (op == 4 || op == 5)                squash_left[k] = cfg_br[k];
      if (op == 2 || op == 3)                squash_left[k] = cfg_jmp[k];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_advance(k);
    #1;
  endtask

  task automatic idle_cycles(int n);
    rst = 1'b0; id_valid = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0; id_instr = 32'd0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    logic [6:0] a;
    rst = 1'b1; id_valid = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5; id_instr = 32'h00A73020;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      a = get_act(k);
      checks++;
      if (a !== NEUTRAL) begin
        failures++;
        $display("[TB] FAIL reset_hold dut%0d got=%b want=%b", k, a, NEUTRAL);
      end
    end
    tick();
    idle_cycles(0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      a = get_act(k);
      checks++;
      if (a !== NEUTRAL) begin
        failures++;
        $display("[TB] FAIL reset_release dut%0d got=%b want=%b", k, a, NEUTRAL);
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] t_instr [7] = '{32'h00A73020, 32'h00A73020, 32'h00A73020, 32'h00A73020,
                                 32'h8C450000, 32'hAC450000, 32'h00A73020};
    logic        t_mr    [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0]  t_rt    [7] = '{5'd5, 5'd5, 5'd7, 5'd0, 5'd5, 5'd5, 5'd5};
    logic        t_val   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0]  t_exp   [7] = '{7'b0001001, NEUTRAL, 7'b0001001, NEUTRAL,
                                 NEUTRAL, 7'b0001001, NEUTRAL};
    logic [6:0]  a;
    for (int i = 0; i < 7; i++) begin
      id_instr = t_instr[i]; ex_memread = t_mr[i]; ex_rt = t_rt[i]; id_valid = t_val[i];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        a = get_act(k);
        checks++;
        if (a !== t_exp[i]) begin
          failures++;
          $display("[TB] FAIL load_use step%0d dut%0d got=%b want=%b", i, k, a, t_exp[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_blocking_mult();
    logic [6:0] a, e;
    id_instr = 32'h00430019; id_valid = 1'b1; ex_memread = 1'b0; ex_rt = 5'd0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      a = get_act(k);
      checks++;
      if (a !== NEUTRAL) begin
        failures++;
        $display("[TB] FAIL mult_accept dut%0d got=%b want=%b", k, a, NEUTRAL);
      end
    end
    tick();
    id_instr = 32'h00A73020;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        a = get_act(k);
        if (k == 0) e = (i < 32) ? 7'b0001110 : NEUTRAL;
        else        e = model_out(k);
        checks++;
        if (a !== e) begin
          failures++;
          $display("[TB] FAIL blocking_mult cyc%0d dut%0d got=%b want=%b", i, k, a, e);
        end
      end
      tick();
    end
  endtask

  task automatic test_nonblocking_div();
    logic [6:0] a, e;
    id_valid = 1'b1; ex_memread = 1'b0; ex_rt = 5'd0;
    for (int i = 0; i < 10; i++) begin
      id_instr = (i == 0) ? 32'h0043001A : (i <= 3) ? 32'h00A73020 : 32'h00001012;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        a = get_act(k);
        if (k == 1) e = (i == 0) ? NEUTRAL : (i <= 3) ? 7'b1100100 :
                        (i <= 8) ? 7'b0001110 : NEUTRAL;
        else        e = model_out(k);
        checks++;
        if (a !== e) begin
          failures++;
          $display("[TB] FAIL nonblocking_div cyc%0d dut%0d got=%b want=%b", i, k, a, e);
        end
      end
      tick();
    end
    idle_cycles(40);
  endtask

  task automatic test_control(logic [31:0] instr, int want0, int want1, int want2);
    int         flushes [3] = '{0, 0, 0};
    int         want    [3];
    logic [6:0] a, e;
    want[0] = want0; want[1] = want1; want[2] = want2;
    ex_memread = 1'b0; ex_rt = 5'd0;
    for (int i = 0; i < 7; i++) begin
      id_instr = (i == 0) ? instr : 32'h00A73020;
      id_valid = (i == 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        a = get_act(k);
        e = model_out(k);
        if (a[4]) flushes[k]++;
        checks++;
        if (a !== e) begin
          failures++;
          $display("[TB] FAIL control_%h cyc%0d dut%0d got=%b want=%b", instr, i, k, a, e);
        end
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (flushes[k] != want[k]) begin
        failures++;
        $display("[TB] FAIL flush_count_%h dut%0d got=%0d want=%0d", instr, k, flushes[k], want[k]);
      end
    end
  endtask

  task automatic test_priority();
    logic [6:0] a, e;
    id_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      id_instr   = (i == 0) ? 32'h00430019 : 32'h00A00010;
      ex_memread = (i == 1);
      ex_rt      = 5'd5;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        a = get_act(k);
        if (k == 1) e = (i == 0) ? NEUTRAL : (i == 1) ? 7'b0001101 :
                        (i <= 5) ? 7'b0001110 : NEUTRAL;
        else        e = model_out(k);
        checks++;
        if (a !== e) begin
          failures++;
          $display("[TB] FAIL priority cyc%0d dut%0d got=%b want=%b", i, k, a, e);
        end
      end
      tick();
    end
    idle_cycles(40);
  endtask

  task automatic test_reset_mid();
    logic [6:0] a, e;
    ex_memread = 1'b0; ex_rt = 5'd0;
    for (int i = 0; i < 7; i++) begin
      rst      = (i == 3);
      id_valid = (i <= 1);
      id_instr = (i == 0) ? 32'h0043001A : 32'h0C000010;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        a = get_act(k);
        if (i >= 3)       e = NEUTRAL;
        else if (k == 1)  e = (i == 0) ? NEUTRAL : (i == 1) ? 7'b1100100 : 7'b1110111;
        else              e = model_out(k);
        checks++;
        if (a !== e) begin
          failures++;
          $display("[TB] FAIL reset_mid cyc%0d dut%0d got=%b want=%b", i, k, a, e);
        end
      end
      tick();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    logic [4:0] rd = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 9))
      0:       return {6'd0, rs, rt, rd, 5'd0, 6'd32};
      1:       return {6'd0, rs, rt, 10'd0, 6'(24 + $urandom_range(0, 3))};
      2:       return {6'd0, rs, 5'd0, rd, 5'd0, ($urandom_range(0, 1) != 0) ? 6'd16 : 6'd18};
      3:       return {6'(4 + $urandom_range(0, 1)), rs, rt, 16'($urandom)};
      4:       return {6'(2 + $urandom_range(0, 1)), 26'($urandom)};
      5:       return {6'd35, rs, rt, 16'($urandom)};
      6:       return {6'd43, rs, rt, 16'($urandom)};
      7:       return 32'($urandom);
      default: return {6'd13, rs, rt, 16'($urandom)};
    endcase
  endfunction

  task automatic test_random();
    logic [6:0] a, e;
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      id_valid   = ($urandom_range(0, 9) < 8);
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_rt      = 5'($urandom_range(0, 7));
      id_instr   = rand_instr();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        a = get_act(k);
        e = model_out(k);
        checks++;
        if (a !== e) begin
          failures++;
          $display("[TB] FAIL random n%0d dut%0d instr=%h got=%b want=%b", n, k, id_instr, a, e);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0; id_instr = 32'd0;
    test_reset();
    test_load_use();
    test_blocking_mult();
    test_nonblocking_div();
    test_control(32'h10000003, 1, 2, 0);
    test_control(32'h0C000010, 3, 3, 0);
    test_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
